thread_fetch_sched: RTL and testbench
=====================================

// Module: thread_fetch_sched
// PURPOSE
//  Fine-grained fetch thread scheduler for the 2-thread CVA6 core.
//  Each cycle it picks the hardware thread whose PC the frontend fetches next.
//  It sits between the per-thread status sources (CSR enable, icache miss, WFI, flush)
//  and the frontend PC select.
//  Round-robin among eligible threads, with a bounded quantum, so that one thread
//  cannot starve the other.
// PARAMETERS
//  NUM_THREADS      2  number of hardware threads (cva6_cfg.NUM_THREADS)
//  NUM_THREADS_LOG  1  log2(NUM_THREADS), width of thread ids
//  MAX_QUANTUM      4  max consecutive accepted fetches per thread while another is eligible (>=1)
// PORTS
//  clk_i           in   1                clock
//  rst_i           in   1                synchronous active-high reset
//  thread_en_i     in   NUM_THREADS      thread enabled (CSR/hart-run state)
//  thread_stall_i  in   NUM_THREADS      thread cannot fetch (icache miss, WFI, ID queue full)
//  flush_i         in   NUM_THREADS      thread redirect/flush this cycle
//  fetch_ready_i   in   1                frontend accepts the current grant
//  fetch_valid_o   out  1                grant valid
//  fetch_tid_o     out  NUM_THREADS_LOG  granted thread id
//  switch_o        out  1                pulse: fetch_tid_o differs from the previous valid grant
// BEHAVIOUR
//  - All outputs are registered. Reset values: fetch_valid_o=0, fetch_tid_o=0, switch_o=0,
//    quantum counter=0, last_tid=0, state=IDLE.
//  - eligible[t] = thread_en_i[t] & ~thread_stall_i[t] & ~flush_i[t], from current-cycle inputs.
//  - accept = fetch_valid_o & fetch_ready_i.
//  - FSM states: IDLE (no grant), RUN (grant held).
//  - Next-thread search: round-robin starting at (cur_tid+1) mod NUM_THREADS and wrapping.
//    cur_tid is included last.
//  - IDLE:
//    - If any thread is eligible, go to RUN next cycle.
//    - Grant the first eligible thread after last_tid, reset quantum to 0.
//    - Otherwise stay in IDLE.
//  - RUN, current thread ineligible (stall, disable or flush):
//    - Withdraw the grant the next cycle, even if accept is seen this cycle.
//    - Re-select per the next-thread search, excluding the current thread.
//    - If none is eligible, go to IDLE and keep last_tid = cur_tid.
//  - RUN, current thread eligible, no accept: hold tid and valid stable. The counter does not move.
//  - RUN, current thread eligible, accept:
//    - Counter +1.
//    - If the counter reaches MAX_QUANTUM-1 and another thread is eligible, switch to it and
//      reset the counter to 0.
//    - Otherwise the counter saturates at MAX_QUANTUM-1 and the thread continues.
//  - A sole eligible thread is never preempted: the quantum applies only with a competitor.
//  - Latency: an eligibility change is reflected at the outputs exactly 1 cycle later.
//  - switch_o=1 for the one cycle in which a new grant's tid != last granted tid.
//    Re-entering RUN from IDLE with the same tid gives switch_o=0.
//  - Simultaneous flush_i on all threads: go to IDLE for 1 cycle, then re-arbitrate.
//  - rst_i asserted mid-operation: outputs return to reset values on the next edge,
//    regardless of fetch_ready_i.
//  - Counter width is $clog2(MAX_QUANTUM)+1. With MAX_QUANTUM=1 the scheduler switches
//    on every accept.
// STRUCTURE
//  - Shared package (ariane_pkg/mt additions):
//    - typedef logic [NUM_THREADS_LOG-1:0] tid_t
//    - typedef enum logic {SCHED_IDLE, SCHED_RUN} sched_state_e
//  - Sub-module thread_rr_pick (combinational):
//    - Inputs: eligible mask, start index, exclude mask.
//    - Outputs: found, tid.
//    - Reusable by issue-stage thread selection.
//  - This module instantiates one thread_rr_pick and holds the FSM, tid, counter and
//    switch registers.
// TESTING
//  - Reset, then en=2'b11, stall=0, ready=1 -> valid=1 one cycle after reset.
//    Tids: 0,0,0,0,1,1,1,1,0 (MAX_QUANTUM=4); switch_o pulses when tid goes 0->1 and 1->0.
//  - en=2'b01, ready=1 for 20 cycles -> tid stays 0, valid stays 1, switch_o never asserts.
//  - Tid=0 granted, stall_i[0]=1 for 1 cycle -> next cycle tid=1, switch_o=1.
//    Counter restarts at 0.
//  - ready=0 for 5 cycles with both threads eligible -> tid and valid hold.
//    The quantum does not advance; after ready=1, four more accepts precede the switch.
//  - flush_i=2'b11 while in RUN -> valid=0 the next cycle, then a grant resumes at
//    (last_tid+1) mod 2 with switch_o=1 if that tid differs.
//  - rst_i=1 while valid=1 and ready=0 -> next cycle valid=0, tid=0, switch_o=0.
//    Checked at each FSM state.

Source files
------------

// File: rtl/thread_fetch_sched_pkg.sv
// Shared types and constants for the multithreaded fetch scheduler.
package thread_fetch_sched_pkg;

  localparam int NUM_THREADS     = 2;
  localparam int NUM_THREADS_LOG = 1;
  localparam int MAX_QUANTUM     = 4;

  typedef logic [NUM_THREADS_LOG-1:0] tid_t;

  typedef enum logic {SCHED_IDLE, SCHED_RUN} sched_state_e;

  // Next thread id in round-robin order, wrapping after the last thread.
  function automatic tid_t tid_inc(tid_t t);
    if (int'(t) == NUM_THREADS - 1) begin
      return '0;
    end
    return t + tid_t'(1);
  endfunction

endpackage

// File: rtl/thread_fetch_sched_rr_pick.sv
// Combinational round-robin picker: first eligible, non-excluded thread
// starting at start_i and wrapping. Shared with issue-stage thread selection.
module thread_rr_pick
  import thread_fetch_sched_pkg::*;
(
  input  logic [NUM_THREADS-1:0] eligible_i,
  input  tid_t                   start_i,
  input  logic [NUM_THREADS-1:0] exclude_i,
  output logic                   found_o,
  output tid_t                   tid_o
);

  // Walk the threads from start_i in wrap-around order, first hit wins.
  always_comb begin
    tid_t idx;
    found_o = 1'b0;
    tid_o   = start_i;
    idx     = start_i;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!found_o && eligible_i[idx] && !exclude_i[idx]) begin
        found_o = 1'b1;
        tid_o   = idx;
      end
      idx = tid_inc(idx);
    end
  end

endmodule

// File: rtl/thread_fetch_sched.sv
// Fetch thread scheduler: picks which hardware thread the frontend fetches
// next, round-robin among eligible threads with a bounded quantum.
module thread_fetch_sched
  import thread_fetch_sched_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_THREADS-1:0]     thread_en_i,
  input  logic [NUM_THREADS-1:0]     thread_stall_i,
  input  logic [NUM_THREADS-1:0]     flush_i,
  input  logic                       fetch_ready_i,
  output logic                       fetch_valid_o,
  output logic [NUM_THREADS_LOG-1:0] fetch_tid_o,
  output logic                       switch_o
);

  localparam int               CNT_W   = $clog2(MAX_QUANTUM) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_QUANTUM - 1);

  sched_state_e     state_q, state_d;
  tid_t             tid_q, tid_d;
  tid_t             last_tid_q, last_tid_d;
  logic             valid_q, valid_d;
  logic             switch_q, switch_d;
  logic             started_q, started_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_THREADS-1:0] eligible;
  logic [NUM_THREADS-1:0] exclude;
  tid_t                   pick_start;
  logic                   pick_found;
  tid_t                   pick_tid;
  logic                   cur_elig;
  logic                   accept;

  assign eligible = thread_en_i & ~thread_stall_i & ~flush_i;
  assign cur_elig = eligible[tid_q];
  assign accept   = valid_q & fetch_ready_i;

  // Search start and exclusion: from IDLE resume after the last grant (thread 0
  // before any grant), from RUN look past the current thread and skip it.
  always_comb begin
    exclude    = '0;
    pick_start = started_q ? tid_inc(last_tid_q) : '0;
    if (state_q == SCHED_RUN) begin
      exclude[tid_q] = 1'b1;
      pick_start     = tid_inc(tid_q);
    end
  end

  thread_rr_pick u_pick (
    .eligible_i (eligible),
    .start_i    (pick_start),
    .exclude_i  (exclude),
    .found_o    (pick_found),
    .tid_o      (pick_tid)
  );

  // State register plus the registered outputs, counter and history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SCHED_IDLE;
      tid_q      <= '0;
      last_tid_q <= '0;
      valid_q    <= 1'b0;
      switch_q   <= 1'b0;
      started_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tid_q      <= tid_d;
      last_tid_q <= last_tid_d;
      valid_q    <= valid_d;
      switch_q   <= switch_d;
      started_q  <= started_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state: RUN while some thread holds a grant, IDLE otherwise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCHED_IDLE: if (pick_found) state_d = SCHED_RUN;
      SCHED_RUN:  if (!cur_elig && !pick_found) state_d = SCHED_IDLE;
      default:    state_d = SCHED_IDLE;
    endcase
  end

  // Grant, quantum counter and switch pulse for the next cycle.
  always_comb begin
    valid_d    = (state_d == SCHED_RUN);
    tid_d      = tid_q;
    last_tid_d = last_tid_q;
    started_d  = started_q;
    cnt_d      = cnt_q;
    switch_d   = 1'b0;
    if (state_q == SCHED_IDLE) begin
      if (pick_found) begin
        tid_d      = pick_tid;
        last_tid_d = pick_tid;
        started_d  = 1'b1;
        cnt_d      = '0;
        switch_d   = started_q && (pick_tid != last_tid_q);
      end
    end else if (!cur_elig) begin
      // Current thread dropped out: its grant goes away even if accepted now.
      cnt_d = '0;
      if (pick_found) begin
        tid_d      = pick_tid;
        last_tid_d = pick_tid;
        switch_d   = 1'b1;
      end
    end else if (accept) begin
      // Quantum only expires when a competitor is waiting; otherwise saturate.
      if (cnt_q == CNT_MAX && pick_found) begin
        tid_d      = pick_tid;
        last_tid_d = pick_tid;
        cnt_d      = '0;
        switch_d   = 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign fetch_valid_o = valid_q;
  assign fetch_tid_o   = tid_q;
  assign switch_o      = switch_q;

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Self-checking bench for thread_fetch_sched: directed scenarios plus a
// randomized run against a behavioural scheduler model.
module tb_thread_fetch_sched;
  import thread_fetch_sched_pkg::*;

  localparam int NT = NUM_THREADS;
  localparam int MQ = MAX_QUANTUM;

  logic          clk;
  logic          rst;
  logic [NT-1:0] en;
  logic [NT-1:0] stall;
  logic [NT-1:0] flush;
  logic          ready;
  logic          fetch_valid;
  tid_t          fetch_tid;
  logic          sw;

  int checks;
  int errors;

  // Behavioural model state: grant, accepts used in the current grant,
  // last granted thread and whether any grant has happened since reset.
  bit m_valid;
  int m_tid;
  int m_used;
  int m_last;
  bit m_started;
  bit m_sw;

  thread_fetch_sched dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .thread_en_i    (en),
    .thread_stall_i (stall),
    .flush_i        (flush),
    .fetch_ready_i  (ready),
    .fetch_valid_o  (fetch_valid),
    .fetch_tid_o    (fetch_tid),
    .switch_o       (sw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pick_after(int after, int excl, logic [NT-1:0] el);
    for (int k = 1; k <= NT; k++) begin
      int t;
      t = (after + k) % NT;
      if (t != excl && el[t]) return t;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [NT-1:0] el;
    int p;
    if (rst) begin
      m_valid = 0; m_tid = 0; m_used = 0; m_last = 0; m_started = 0; m_sw = 0;
      return;
    end
    el   = en & ~stall & ~flush;
    m_sw = 0;
    if (!m_valid) begin
      p = pick_after(m_started ? m_last : NT - 1, -1, el);
      if (p >= 0) begin
        m_sw = m_started && (p != m_last);
        m_valid = 1; m_tid = p; m_used = 0; m_last = p; m_started = 1;
      end
    end else if (!el[m_tid]) begin
      p = pick_after(m_tid, m_tid, el);
      if (p >= 0) begin
        m_sw = 1; m_tid = p; m_used = 0; m_last = p;
      end else begin
        m_valid = 0;
      end
    end else if (ready) begin
      p = pick_after(m_tid, m_tid, el);
      if (m_used >= MQ - 1 && p >= 0) begin
        m_sw = 1; m_tid = p; m_used = 0; m_last = p;
      end else begin
        m_used++;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = '0; stall = '0; flush = '0; ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fetch_valid); end
    checks++;
    if (fetch_tid !== '0) begin errors++; $display("FAIL reset_tid got %0d want 0", fetch_tid); end
    checks++;
    if (sw !== 1'b0) begin errors++; $display("FAIL reset_switch got %b want 0", sw); end
  endtask

  task automatic test_round_robin();
    int exp_tid [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    bit exp_sw  [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    en = 2'b11; ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== tid_t'(exp_tid[i]) || sw !== exp_sw[i]) begin
        errors++;
        $display("FAIL rr_seq[%0d] got v=%b tid=%0d sw=%b want v=1 tid=%0d sw=%b",
                 i, fetch_valid, fetch_tid, sw, exp_tid[i], exp_sw[i]);
      end
    end
  endtask

  task automatic test_sole_thread();
    do_reset();
    en = 2'b01; ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== tid_t'(0) || sw !== 1'b0) begin
        errors++;
        $display("FAIL sole[%0d] got v=%b tid=%0d sw=%b want v=1 tid=0 sw=0",
                 i, fetch_valid, fetch_tid, sw);
      end
    end
  endtask

  task automatic test_stall_switch();
    do_reset();
    en = 2'b11; ready = 1'b1;
    cycle();
    checks++;
    if (fetch_tid !== tid_t'(0)) begin errors++; $display("FAIL stall_pre tid got %0d want 0", fetch_tid); end
    stall = 2'b01;
    cycle();
    stall = 2'b00;
    checks++;
    if (fetch_valid !== 1'b1 || fetch_tid !== tid_t'(1) || sw !== 1'b1) begin
      errors++;
      $display("FAIL stall_switch got v=%b tid=%0d sw=%b want v=1 tid=1 sw=1", fetch_valid, fetch_tid, sw);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (fetch_tid !== tid_t'(i < 3 ? 1 : 0) || sw !== (i == 3)) begin
        errors++;
        $display("FAIL stall_quantum[%0d] got tid=%0d sw=%b want tid=%0d sw=%b",
                 i, fetch_tid, sw, (i < 3 ? 1 : 0), (i == 3));
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    en = 2'b11; ready = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== tid_t'(0) || sw !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got v=%b tid=%0d sw=%b want v=1 tid=0 sw=0", i, fetch_valid, fetch_tid, sw);
      end
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (fetch_tid !== tid_t'(i < 3 ? 0 : 1) || sw !== (i == 3)) begin
        errors++;
        $display("FAIL hold_resume[%0d] got tid=%0d sw=%b want tid=%0d sw=%b",
                 i, fetch_tid, sw, (i < 3 ? 0 : 1), (i == 3));
      end
    end
  endtask

  task automatic test_flush_all();
    int prev;
    do_reset();
    en = 2'b11; ready = 1'b1;
    cycle();
    prev = int'(fetch_tid);
    flush = 2'b11;
    cycle();
    flush = 2'b00;
    checks++;
    if (fetch_valid !== 1'b0 || sw !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle got v=%b sw=%b want v=0 sw=0", fetch_valid, sw);
    end
    cycle();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_tid !== tid_t'((prev + 1) % NT) || sw !== 1'b1) begin
      errors++;
      $display("FAIL flush_resume got v=%b tid=%0d sw=%b want v=1 tid=%0d sw=1",
               fetch_valid, fetch_tid, sw, (prev + 1) % NT);
    end
  endtask

  task automatic test_reset_mid();
    // RUN on thread 1 right after a switch, frontend not ready.
    do_reset();
    en = 2'b11; ready = 1'b0;
    cycle();
    stall = 2'b01;
    cycle();
    stall = 2'b00;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_tid !== tid_t'(0) || sw !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_run got v=%b tid=%0d sw=%b want v=0 tid=0 sw=0", fetch_valid, fetch_tid, sw);
    end
    // IDLE: nothing enabled.
    en = 2'b00;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_tid !== tid_t'(0) || sw !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_idle got v=%b tid=%0d sw=%b want v=0 tid=0 sw=0", fetch_valid, fetch_tid, sw);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int t = 0; t < NT; t++) begin
        en[t]    = ($urandom_range(0, 7) != 0);
        stall[t] = ($urandom_range(0, 3) == 0);
        flush[t] = ($urandom_range(0, 9) == 0);
      end
      ready = ($urandom_range(0, 3) != 0);
      cycle();
      checks++;
      if (fetch_valid !== m_valid || sw !== m_sw ||
          (m_valid && fetch_tid !== tid_t'(m_tid))) begin
        errors++;
        $display("FAIL random[%0d] got v=%b tid=%0d sw=%b want v=%b tid=%0d sw=%b",
                 i, fetch_valid, fetch_tid, sw, m_valid, m_tid, m_sw);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = '0; stall = '0; flush = '0; ready = 1'b0;
    m_valid = 0; m_tid = 0; m_used = 0; m_last = 0; m_started = 0; m_sw = 0;
    test_reset();
    test_round_robin();
    test_sole_thread();
    test_stall_switch();
    test_hold();
    test_flush_all();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
